// File: rtl/key_search_pkg.sv
// Shared state encoding and parameter defaults for the arcfour key sweep.
package key_search_pkg;

  localparam int KEY_WIDTH_DEFAULT      = 24;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_LOAD      = 3'd1;
  localparam state_t S_LAUNCH    = 3'd2;
  localparam state_t S_WAIT      = 3'd3;
  localparam state_t S_CHECK     = 3'd4;
  localparam state_t S_FOUND     = 3'd5;
  localparam state_t S_EXHAUSTED = 3'd6;
  localparam state_t S_TIMEOUT   = 3'd7;

endpackage

// File: rtl/key_search_watchdog_counter.sv
// Per-key watchdog: counts enabled cycles from a clear; terminal flags the last allowed cycle.
// Combinational terminal output, no backpressure.
module watchdog_counter #(
  parameter int TIMEOUT_CYCLES = key_search_pkg::TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/key_search.sv
// Sweeps candidate keys into arcfour, one reset/start pair per key, stopping on success,
// range exhaustion or watchdog timeout. Per-key overhead is four cycles plus arcfour latency.
module key_search
  import key_search_pkg::*;
#(
  parameter int                   KEY_WIDTH      = KEY_WIDTH_DEFAULT,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST      = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST       = 24'h3FFFFF,
  parameter int                   TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 arc_finished,
  input  logic                 arc_success,
  output logic                 arc_reset,
  output logic                 arc_start,
  output logic [2:0][7:0]      switch_key,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 timeout,
  output logic [KEY_WIDTH-1:0] attempts
);

  if (KEY_FIRST > KEY_LAST) begin : g_bad_range
    $error("key_search: KEY_FIRST must not exceed KEY_LAST");
  end
  if (KEY_WIDTH != 24) begin : g_bad_width
    $error("key_search: switch_key is three bytes, KEY_WIDTH must be 24");
  end

  state_t               state;
  logic [KEY_WIDTH-1:0] key;
  logic                 success_q;
  logic                 wd_terminal;

  watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == S_LAUNCH),
    .enable  (state == S_WAIT),
    .terminal(wd_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      key       <= KEY_FIRST;
      attempts  <= '0;
      success_q <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_TIMEOUT: begin
          if (go && !abort) begin
            key      <= KEY_FIRST;
            attempts <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD:   state <= S_LAUNCH;
        S_LAUNCH: state <= S_WAIT;
        // arc_finished is only trusted here, after this key's reset has cleared any stale flag.
        S_WAIT: begin
          if (arc_finished) begin
            success_q <= arc_success;
            state     <= S_CHECK;
          end else if (wd_terminal) begin
            state <= S_TIMEOUT;
          end
        end
        S_CHECK: begin
          attempts <= attempts + 1'b1;
          if (success_q) begin
            state <= S_FOUND;
          end else if (key == KEY_LAST) begin
            state <= S_EXHAUSTED;
          end else begin
            key   <= key + 1'b1;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arc_reset  = (state == S_LOAD);
  assign arc_start  = (state == S_LAUNCH);
  assign busy       = (state == S_LOAD) || (state == S_LAUNCH) ||
                      (state == S_WAIT) || (state == S_CHECK);
  assign found      = (state == S_FOUND);
  assign exhausted  = (state == S_EXHAUSTED);
  assign timeout    = (state == S_TIMEOUT);
  assign switch_key = key;

endmodule

// File: tb/tb_key_search.sv
// Directed bench for key_search: four instances (sweep/abort, short range, top-of-range, stale flag).
// A cycle-indexed arithmetic model of a search run is compared every cycle on instances 0-2.
module tb_key_search;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] rst_v = 4'hF;
  logic [3:0] go_v = '0;
  logic [3:0] abort_v = '0;
  logic [3:0] fin_v, suc_v;
  logic [3:0] arst_o, ast_o, busy_o, fnd_o, exh_o, to_o;
  logic [23:0] key_o[4];
  logic [23:0] att_o[4];
  logic        d_fin = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_search #(.KEY_FIRST(24'h000000), .KEY_LAST(24'h3FFFFF), .TIMEOUT_CYCLES(64)) u_a (
    .clk(clk), .reset(rst_v[0]), .go(go_v[0]), .abort(abort_v[0]),
    .arc_finished(fin_v[0]), .arc_success(suc_v[0]), .arc_reset(arst_o[0]), .arc_start(ast_o[0]),
    .switch_key(key_o[0]), .busy(busy_o[0]), .found(fnd_o[0]), .exhausted(exh_o[0]),
    .timeout(to_o[0]), .attempts(att_o[0]));
  key_search #(.KEY_FIRST(24'h000005), .KEY_LAST(24'h000007), .TIMEOUT_CYCLES(64)) u_b (
    .clk(clk), .reset(rst_v[1]), .go(go_v[1]), .abort(abort_v[1]),
    .arc_finished(fin_v[1]), .arc_success(suc_v[1]), .arc_reset(arst_o[1]), .arc_start(ast_o[1]),
    .switch_key(key_o[1]), .busy(busy_o[1]), .found(fnd_o[1]), .exhausted(exh_o[1]),
    .timeout(to_o[1]), .attempts(att_o[1]));
  key_search #(.KEY_FIRST(24'hFFFFFF), .KEY_LAST(24'hFFFFFF), .TIMEOUT_CYCLES(64)) u_c (
    .clk(clk), .reset(rst_v[2]), .go(go_v[2]), .abort(abort_v[2]),
    .arc_finished(fin_v[2]), .arc_success(suc_v[2]), .arc_reset(arst_o[2]), .arc_start(ast_o[2]),
    .switch_key(key_o[2]), .busy(busy_o[2]), .found(fnd_o[2]), .exhausted(exh_o[2]),
    .timeout(to_o[2]), .attempts(att_o[2]));
  key_search #(.KEY_FIRST(24'h000000), .KEY_LAST(24'h3FFFFF), .TIMEOUT_CYCLES(16)) u_d (
    .clk(clk), .reset(rst_v[3]), .go(go_v[3]), .abort(abort_v[3]),
    .arc_finished(fin_v[3]), .arc_success(suc_v[3]), .arc_reset(arst_o[3]), .arc_start(ast_o[3]),
    .switch_key(key_o[3]), .busy(busy_o[3]), .found(fnd_o[3]), .exhausted(exh_o[3]),
    .timeout(to_o[3]), .attempts(att_o[3]));

  // Arcfour stand-in: finished goes high LAT cycles into WAIT and stays until the next arc_reset.
  int          af_lat[3];
  int          af_cnt[3];
  logic        af_run[3];
  logic [23:0] af_key[3];
  logic [23:0] af_win[3];
  logic        af_haswin[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (arst_o[i]) begin
        af_run[i] <= 1'b0;
      end else if (ast_o[i]) begin
        af_run[i] <= 1'b1;
        af_cnt[i] <= 0;
        af_key[i] <= key_o[i];
      end else if (af_run[i]) begin
        af_cnt[i] <= af_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    fin_v = '0;
    suc_v = '0;
    for (int i = 0; i < 3; i++) begin
      fin_v[i] = af_run[i] && (af_cnt[i] >= af_lat[i]);
      suc_v[i] = fin_v[i] && af_haswin[i] && (af_key[i] == af_win[i]);
    end
    fin_v[3] = d_fin;
    suc_v[3] = 1'b1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Run model: after go at cycle g, key idx occupies cycles g+1+idx*P .. g+idx*P+P, P = lat+4.
  logic   m_act[3];
  int     m_g[3], m_p[3], m_nk[3];
  longint m_first[3];
  logic   m_found[3];
  int     starts[3];
  longint max_key[3];
  logic   saw_zero[3];
  int     d_rst_cnt = 0;
  int     rel, idx, off;
  logic   e_busy, e_rst, e_st, e_fnd, e_exh;
  longint e_key, e_att;

  initial for (int i = 0; i < 3; i++) m_act[i] = 1'b0;

  always @(negedge clk) begin
    d_rst_cnt += int'(arst_o[3]);
    for (int i = 0; i < 3; i++) begin
      if (m_act[i] && cyc > m_g[i]) begin
        rel = cyc - m_g[i] - 1;
        idx = rel / m_p[i];
        off = rel % m_p[i];
        if (idx < m_nk[i]) begin
          e_busy = 1'b1; e_rst = (off == 0); e_st = (off == 1);
          e_key = (m_first[i] + idx) & 64'hFFFFFF; e_att = idx;
          e_fnd = 1'b0; e_exh = 1'b0;
        end else begin
          e_busy = 1'b0; e_rst = 1'b0; e_st = 1'b0;
          e_key = (m_first[i] + m_nk[i] - 1) & 64'hFFFFFF; e_att = m_nk[i];
          e_fnd = m_found[i]; e_exh = !m_found[i];
        end
        chk($sformatf("m%0d_busy", i), busy_o[i], e_busy);
        chk($sformatf("m%0d_arc_reset", i), arst_o[i], e_rst);
        chk($sformatf("m%0d_arc_start", i), ast_o[i], e_st);
        chk($sformatf("m%0d_key", i), key_o[i], e_key);
        chk($sformatf("m%0d_attempts", i), att_o[i], e_att);
        chk($sformatf("m%0d_found", i), fnd_o[i], e_fnd);
        chk($sformatf("m%0d_exhausted", i), exh_o[i], e_exh);
        chk($sformatf("m%0d_timeout", i), to_o[i], 0);
        starts[i] += int'(ast_o[i]);
        if (key_o[i] > max_key[i]) max_key[i] = key_o[i];
        if (key_o[i] == 0) saw_zero[i] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int i, input longint first, input int nk, input int lat,
                           input logic fnd, input logic [23:0] win, input logic haswin);
    m_act[i] = 1'b0;
    af_lat[i] = lat; af_win[i] = win; af_haswin[i] = haswin;
    m_g[i] = cyc; m_p[i] = lat + 4; m_nk[i] = nk; m_first[i] = first; m_found[i] = fnd;
    starts[i] = 0; max_key[i] = 0; saw_zero[i] = 1'b0;
    m_act[i] = 1'b1;
    go_v[i] = 1'b1;
    tick();
    go_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string nm);
    int n = 0;
    while (!(fnd_o[i] || exh_o[i] || to_o[i]) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, fnd_o[i] || exh_o[i] || to_o[i], 1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  int g;

  initial begin
    for (int i = 0; i < 3; i++) begin
      af_lat[i] = 1; af_run[i] = 1'b0; af_cnt[i] = 0; af_haswin[i] = 1'b0;
    end
    repeat (3) tick();
    rst_v = '0;
    tick();
    chk("rst_key_a", key_o[0], 24'h000000);
    chk("rst_key_b", key_o[1], 24'h000005);
    chk("rst_key_c", key_o[2], 24'hFFFFFF);
    chk("rst_busy_a", busy_o[0], 0);
    chk("rst_flags_a", {arst_o[0], ast_o[0], fnd_o[0], exh_o[0], to_o[0]}, 0);
    chk("rst_attempts_b", att_o[1], 0);

    // Success on key 2, latency 10; go pulses while busy must be ignored.
    g = cyc;
    start_run(0, 0, 3, 10, 1'b1, 24'h000002, 1'b1);
    chk("a_arc_reset_g1", arst_o[0], 1);
    tick();
    chk("a_arc_start_g2", ast_o[0], 1);
    go_v[0] = 1'b1; tick(); go_v[0] = 1'b0;
    wait_until(g + 14);
    go_v[0] = 1'b1; tick(); tick(); go_v[0] = 1'b0;
    wait_done(0, 200, "a_found_reached");
    chk("a_found_cycle", cyc, g + 43);
    chk("a_found", fnd_o[0], 1);
    chk("a_key", key_o[0], 24'h000002);
    chk("a_attempts", att_o[0], 3);
    tick(); tick();
    chk("a_start_pulses", starts[0], 3);

    // Restart from FOUND.
    start_run(0, 0, 3, 10, 1'b1, 24'h000002, 1'b1);
    chk("restart_attempts0", att_o[0], 0);
    chk("restart_key0", key_o[0], 0);
    wait_done(0, 200, "restart_found_reached");
    chk("restart_attempts", att_o[0], 3);

    // Abort during WAIT of key 4.
    g = cyc;
    start_run(0, 0, 101, 10, 1'b1, 24'h000064, 1'b1);
    wait_until(g + 62);
    m_act[0] = 1'b0;
    abort_v[0] = 1'b1; tick(); abort_v[0] = 1'b0;
    chk("abort_busy", busy_o[0], 0);
    chk("abort_key_held", key_o[0], 4);
    chk("abort_attempts_held", att_o[0], 4);
    chk("abort_flags", {fnd_o[0], exh_o[0], to_o[0]}, 0);
    tick();
    chk("abort_stays_idle", busy_o[0], 0);

    // abort and go together, first in WAIT then in IDLE.
    start_run(0, 0, 101, 10, 1'b1, 24'h000064, 1'b1);
    repeat (4) tick();
    m_act[0] = 1'b0;
    go_v[0] = 1'b1; abort_v[0] = 1'b1; tick(); go_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("abortgo_wait_busy", busy_o[0], 0);
    tick();
    chk("abortgo_wait_noload", {busy_o[0], arst_o[0]}, 0);
    go_v[0] = 1'b1; abort_v[0] = 1'b1; tick(); go_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("abortgo_idle_noload", {busy_o[0], arst_o[0]}, 0);

    // Reset during WAIT of key 1.
    g = cyc;
    start_run(0, 0, 101, 10, 1'b1, 24'h000064, 1'b1);
    wait_until(g + 20);
    chk("pre_reset_key", key_o[0], 1);
    m_act[0] = 1'b0;
    rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
    chk("midreset_key", key_o[0], 0);
    chk("midreset_attempts", att_o[0], 0);
    chk("midreset_outs", {busy_o[0], arst_o[0], ast_o[0], fnd_o[0], exh_o[0], to_o[0]}, 0);

    // Exhaustion over 5..7.
    start_run(1, 5, 3, 3, 1'b0, 24'h0, 1'b0);
    wait_done(1, 100, "b_done_reached");
    chk("b_exhausted", exh_o[1], 1);
    chk("b_key", key_o[1], 7);
    chk("b_attempts", att_o[1], 3);
    chk("b_busy", busy_o[1], 0);
    tick(); tick();
    chk("b_max_key", max_key[1], 7);

    // Single key at the top of the key space.
    start_run(2, 24'hFFFFFF, 1, 2, 1'b0, 24'h0, 1'b0);
    wait_done(2, 50, "c_done_reached");
    chk("c_exhausted", exh_o[2], 1);
    chk("c_key", key_o[2], 24'hFFFFFF);
    chk("c_attempts", att_o[2], 1);
    tick(); tick();
    chk("c_no_wrap", saw_zero[2], 0);

    // Stale finished flag through LOAD/LAUNCH, then silence until the watchdog fires.
    d_fin = 1'b1;
    d_rst_cnt = 0;
    g = cyc;
    go_v[3] = 1'b1; tick(); go_v[3] = 1'b0;
    tick();
    tick();
    d_fin = 1'b0;
    wait_until(g + 18);
    chk("d_timeout_c18", to_o[3], 0);
    chk("d_busy_c18", busy_o[3], 1);
    tick();
    chk("d_timeout_c19", to_o[3], 1);
    chk("d_no_check_found", fnd_o[3], 0);
    chk("d_attempts", att_o[3], 0);
    chk("d_one_load", d_rst_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_search.md
# key_search

Upstream controller for the arcfour decryption stage. Sweeps the switch-key space from KEY_FIRST to KEY_LAST and drives arcfour's reset, start and key inputs for each candidate. Waits for arcfour to finish each key and samples its success flag. Stops on the first key that decrypts to a valid message, on exhaustion of the range, or on a watchdog timeout. Sits between the board-level edge detectors and the arcfour instance in the top level.

## Interface
Parameters:
- KEY_WIDTH, 24, width of the candidate key; maps to switch_key as three bytes, byte 2 most significant.
- KEY_FIRST, 24'h000000, first key tried.
- KEY_LAST, 24'h3FFFFF, last key tried; inclusive.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed in WAIT per key.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  single-cycle start pulse, already edge-detected upstream.
- abort  in  1  single-cycle stop pulse.
- arc_finished  in  1  arcfour done flag; level.
- arc_success  in  1  arcfour message-valid flag; meaningful while arc_finished=1.
- arc_reset  out  1  one-cycle reset pulse to arcfour per candidate.
- arc_start  out  1  one-cycle start pulse to arcfour.
- switch_key  out  [2:0][7:0]  current candidate key; stable from LOAD until the next increment.
- busy  out  1  high in LOAD, LAUNCH, WAIT and CHECK.
- found  out  1  high in FOUND; switch_key then holds the winning key.
- exhausted  out  1  high in EXHAUSTED.
- timeout  out  1  high in TIMEOUT.
- attempts  out  KEY_WIDTH  number of keys fully checked since the last go.

## Operation
- Every output resets to 0, except switch_key, which resets to KEY_FIRST.
- IDLE: go loads key=KEY_FIRST and attempts=0, then moves to LOAD.
- LOAD: arc_reset=1 for exactly this cycle. Next state is LAUNCH.
- LAUNCH: arc_start=1 for exactly this cycle. Clears the watchdog. Next state is WAIT.
- WAIT:
  - On arc_finished=1, register arc_success into a flop and move to CHECK.
  - arc_finished is ignored in LOAD and LAUNCH, so a stale flag from the previous key is never sampled.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without arc_finished, move to TIMEOUT.
- CHECK: attempts increments, then:
  - If the registered success is 1, move to FOUND.
  - Else if key==KEY_LAST, move to EXHAUSTED.
  - Else increment key by 1 and move to LOAD.
- Key arithmetic and bounds:
  - The exhaustion compare happens before the increment, so KEY_LAST=2^KEY_WIDTH-1 never wraps the key.
  - KEY_FIRST > KEY_LAST is illegal; an elaboration-time assertion rejects it.
- Terminal states: FOUND, EXHAUSTED and TIMEOUT hold switch_key and attempts until go or reset. go from any of them restarts the search at KEY_FIRST.
- go while busy=1 is ignored.
- abort:
  - From any non-IDLE state, move to IDLE on the next cycle.
  - switch_key and attempts hold their values; all status flags drop to 0.
- abort and go in the same cycle: abort wins, and go is dropped.
- reset mid-search: the block is in IDLE the next cycle with reset values, regardless of arcfour's state.

## Timing
- go at cycle 0 gives: LOAD at 1 (arc_reset), LAUNCH at 2 (arc_start), WAIT from 3.
- arc_finished first seen at cycle N gives CHECK at N+1.
  - found, exhausted or LOAD begins at N+2.
  - attempts shows the new count at N+2.
- Overhead per key is 4 cycles (LOAD, LAUNCH, CHECK and the WAIT sample cycle) plus arcfour's latency.
- The switch_key increment is visible in the same cycle arc_reset is asserted for the new key.
- Watchdog:
  - Counts cycles in WAIT starting at 0.
  - With no arc_finished, timeout=1 from cycle 3+TIMEOUT_CYCLES.
  - Counter width is $clog2(TIMEOUT_CYCLES).

## Structure
- Shared package key_search_pkg holds:
  - the state enum: IDLE, LOAD, LAUNCH, WAIT, CHECK, FOUND, EXHAUSTED, TIMEOUT;
  - KEY_WIDTH_DEFAULT;
  - the default TIMEOUT_CYCLES.
- Sub-module watchdog_counter: clear, enable and terminal-count output, parameterised by TIMEOUT_CYCLES. The main FSM, key register and attempts counter stay in key_search.
- The go and abort edges come from the existing edge_detector instances in the top level, not from inside this block.

## Test plan
- Success on 3rd key: KEY_FIRST=0, and an arcfour model succeeds only on key 2 with 10 cycles latency. Required response: found=1, switch_key=24'h000002, attempts=3, with exactly 3 arc_start pulses.
- Exhaustion: KEY_FIRST=5, KEY_LAST=7, and the model never succeeds. Required response: exhausted=1, switch_key=7, attempts=3, no key 8 is ever driven, and busy=0.
- Full-range boundary: KEY_FIRST=KEY_LAST=24'hFFFFFF, with a failing model. Required response: exhausted=1 with switch_key=24'hFFFFFF and no wrap to 0.
- Timeout with stale flag:
  - The model holds arc_finished=1 through LOAD and LAUNCH, then drops it and never reasserts; TIMEOUT_CYCLES=16.
  - Required response: no CHECK is entered, and timeout=1 exactly at cycle 19 after go.
- Abort and reset mid-search:
  - abort during WAIT on key 4 gives IDLE next cycle with switch_key=4 held.
  - abort and go in the same cycle leaves the block in IDLE.
  - reset during WAIT gives all outputs 0 and switch_key=KEY_FIRST the next cycle.
- Restart: go in FOUND restarts at KEY_FIRST with attempts=0. go pulses while busy=1 change nothing.
